hdmi_layer_mixer: RTL and testbench
===================================

Name: hdmi_layer_mixer

Overview:
- Parametrised N-layer overlay compositor for the oscilloscope HDMI path.
- Takes per-pixel enable/colour pairs from the sub-display blocks (text, frequency, voltage, scale, border and icon overlays) plus a background/wave colour, and resolves them by fixed priority with optional 50 % blending.
- Adds a frame-synchronous software layer mask and a frame counter.
- Sits between the overlay generators and the HDMI TX. Delays vs/hs/de so they stay aligned with the pipelined pixel data.

Parameters:
- NUM_LAYERS, 8, number of overlay layers; layer 0 has the highest priority.
- IDX_W, 3, width of the hit index; must satisfy 2^IDX_W >= NUM_LAYERS.
- VS_POL, 1, active level of vs_in (1 = active-high).
- BLINK_BIT, 5, frame_cnt bit that gates blinking layers (OVL_BLINK_EN only).

Ports:
- pix_clk, in, 1, pixel clock; the only clock.
- rstn_out, in, 1, synchronous active-low reset.
- vs_in, in, 1, vertical sync aligned with the layer inputs.
- hs_in, in, 1, horizontal sync.
- de_in, in, 1, data enable.
- bg_data, in, 24, background/wave colour as RGB888 {r,g,b}.
- layer_en, in, NUM_LAYERS, per-pixel layer hit flags.
- layer_data, in, 24*NUM_LAYERS, layer i colour at bits [24i+23:24i].
- layer_mask, in, NUM_LAYERS, software layer enable; 1 = shown; shadowed per frame.
- blend_half, in, NUM_LAYERS, 1 = layer i is blended 50 % with bg_data.
- blink_mask, in, NUM_LAYERS, layers that blink; used only with OVL_BLINK_EN.
- vs_out, out, 1, vs_in delayed 3 cycles.
- hs_out, out, 1, hs_in delayed 3 cycles.
- de_out, out, 1, de_in delayed 3 cycles.
- r_out, out, 8, composited red.
- g_out, out, 8, composited green.
- b_out, out, 8, composited blue.
- hit_valid, out, 1, a layer won the current output pixel.
- hit_idx, out, IDX_W, index of the winning layer; 0 when hit_valid = 0.
- frame_cnt, out, 8, frame counter.

Behaviour:
- Reset (rstn_out = 0 at a pix_clk edge):
  - All outputs go to 0 and all pipeline stages are cleared.
  - mask_shadow is set to all ones; frame_cnt is set to 0.
  - Reset asserted mid-frame takes effect at the next edge. There is no partial flush; stale pixels are discarded.
- Frame edge:
  - Detected when vs_in, registered against its previous value, transitions to its active level (VS_POL).
  - At that edge: mask_shadow <= layer_mask, and frame_cnt increments, wrapping 255 -> 0.
  - layer_mask changes mid-frame have no effect until the next frame edge.
- Pipeline, fixed latency of 3 cycles for pixels and syncs:
  - S1: register all inputs. eff[i] = layer_en[i] & mask_shadow[i] & de_in, plus blink gating when OVL_BLINK_EN is defined.
  - S2: priority-encode eff, lowest index wins. Register sel_colour, sel_blend, hit, idx, bg.
    - If no bit of eff is set: hit = 0, idx = 0, colour = bg.
  - S3: form the output colour.
    - If hit & sel_blend: each channel = (sel >> 1) + (bg >> 1), truncating, no saturation needed (max 127 + 127 = 254).
    - Otherwise the channel is sel_colour.
    - If delayed de = 0, r/g/b_out = 0 and hit_valid = 0.
- Boundary and simultaneous cases:
  - All layers hit at once: layer 0 wins.
  - The frame edge and a pixel in the same cycle: the new mask applies to that cycle's S1 computation. The vs edge occurs during blanking, so de = 0 there anyway.
  - NUM_LAYERS = 1 is legal; hit_idx is then always 0.

Optional Feature:
- Macro: OVL_BLINK_EN.
- Defined: in S1, eff[i] is additionally ANDed with ~(blink_mask[i] & ~frame_cnt[BLINK_BIT]). With the default BLINK_BIT = 5, a blinking layer is hidden for 32 frames and shown for 32 frames. Latency is unchanged.
- Not defined: blink_mask is ignored, no blink logic is generated, and frame_cnt is still produced.

Test Plan:
- Reset/latency: release reset, drive de_in = 1 with layer_en = 0 and bg_data = 24'h102030 -> RGB = 10/20/30 exactly 3 cycles later. de_out and hs_out are delayed by the same 3 cycles.
- Priority: layer_en = 8'b0000_1100, layer 2 = 24'hFF0000, layer 3 = 24'h00FF00 -> RGB = FF/00/00, hit_valid = 1, hit_idx = 2.
- Mask shadowing: mid-frame set layer_mask[2] = 0 -> layer 2 is still shown until the next vs edge. After the edge the same input gives layer 3: RGB = 00/FF/00, hit_idx = 3.
- Blend: blend_half[0] = 1, layer 0 = 24'hFFFFFF, bg = 24'h000000 -> RGB = 7F/7F/7F. With bg = 24'h020202 -> RGB = 80/80/80.
- Blanking and wrap: de_in = 0 with all layers hit -> RGB = 0 and hit_valid = 0. After 256 vs edges, frame_cnt = 0.
- Blink (OVL_BLINK_EN): blink_mask[1] = 1, only layer 1 hit -> background shown for frame_cnt 0–31, layer 1 shown for 32–63.

Source files
------------

// File: rtl/hdmi_layer_mixer.sv
// Fixed-priority N-layer overlay compositor with optional 50 % blend, per-frame layer mask and frame counter.
// Latency: 3 pix_clk cycles for pixel data and vs/hs/de alike.
// Backpressure: none, a free-running pixel stream with a new pixel accepted every cycle. Optional blinking layers: define OVL_BLINK_EN.
module hdmi_layer_mixer #(
    parameter int   NUM_LAYERS = 8,
    parameter int   IDX_W      = 3,
    parameter logic VS_POL     = 1'b1,
    parameter int   BLINK_BIT  = 5
) (
    input  logic                     pix_clk,
    input  logic                     rstn_out,
    input  logic                     vs_in,
    input  logic                     hs_in,
    input  logic                     de_in,
    input  logic [23:0]              bg_data,
    input  logic [NUM_LAYERS-1:0]    layer_en,
    input  logic [24*NUM_LAYERS-1:0] layer_data,
    input  logic [NUM_LAYERS-1:0]    layer_mask,
    input  logic [NUM_LAYERS-1:0]    blend_half,
    input  logic [NUM_LAYERS-1:0]    blink_mask,
    output logic                     vs_out,
    output logic                     hs_out,
    output logic                     de_out,
    output logic [7:0]               r_out,
    output logic [7:0]               g_out,
    output logic [7:0]               b_out,
    output logic                     hit_valid,
    output logic [IDX_W-1:0]         hit_idx,
    output logic [7:0]               frame_cnt
);

    // Frame tracking
    logic                  vs_prev;
    logic                  frame_edge;
    logic [NUM_LAYERS-1:0] mask_shadow;
    logic [NUM_LAYERS-1:0] mask_now;
    logic [NUM_LAYERS-1:0] eff;

    // A pixel arriving on the frame-edge cycle already sees the new mask.
    assign frame_edge = (vs_in == VS_POL) && (vs_prev != VS_POL);
    assign mask_now   = frame_edge ? layer_mask : mask_shadow;

`ifdef OVL_BLINK_EN
    // Blinking layers are hidden while the selected frame_cnt bit is low.
    assign eff = layer_en & mask_now & {NUM_LAYERS{de_in}}
               & ~(blink_mask & ~{NUM_LAYERS{frame_cnt[BLINK_BIT]}});
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign eff = layer_en & mask_now & {NUM_LAYERS{de_in}};
`endif

    // Latch the software mask and count frames on each active vs edge.
    always_ff @(posedge pix_clk) begin
        if (!rstn_out) begin
            vs_prev     <= 1'b0;
            mask_shadow <= '1;
            frame_cnt   <= 8'd0;
        end else begin
            vs_prev <= vs_in;
            if (frame_edge) begin
                mask_shadow <= layer_mask;
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

    // Stage 1 registers
    logic [NUM_LAYERS-1:0]    s1_eff;
    logic [NUM_LAYERS-1:0]    s1_blend;
    logic [24*NUM_LAYERS-1:0] s1_data;
    logic [23:0]              s1_bg;
    logic                     s1_vs, s1_hs, s1_de;

    // S1: capture inputs together with the masked per-layer hit flags.
    always_ff @(posedge pix_clk) begin
        if (!rstn_out) begin
            s1_eff   <= '0;
            s1_blend <= '0;
            s1_data  <= '0;
            s1_bg    <= '0;
            s1_vs    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_de    <= 1'b0;
        end else begin
            s1_eff   <= eff;
            s1_blend <= blend_half;
            s1_data  <= layer_data;
            s1_bg    <= bg_data;
            s1_vs    <= vs_in;
            s1_hs    <= hs_in;
            s1_de    <= de_in;
        end
    end

    // Priority encoder results
    logic             pe_hit;
    logic             pe_blend;
    logic [IDX_W-1:0] pe_idx;
    logic [23:0]      pe_colour;

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        pe_hit    = 1'b0;
        pe_blend  = 1'b0;
        pe_idx    = '0;
        pe_colour = s1_bg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_eff[i]) begin
                pe_hit    = 1'b1;
                pe_blend  = s1_blend[i];
                pe_idx    = IDX_W'(i);
                pe_colour = s1_data[24*i +: 24];
            end
        end
    end

    // Stage 2 registers
    logic             s2_hit, s2_blend;
    logic [IDX_W-1:0] s2_idx;
    logic [23:0]      s2_colour, s2_bg;
    logic             s2_vs, s2_hs, s2_de;

    // S2: register the winning layer and its colour.
    always_ff @(posedge pix_clk) begin
        if (!rstn_out) begin
            s2_hit    <= 1'b0;
            s2_blend  <= 1'b0;
            s2_idx    <= '0;
            s2_colour <= '0;
            s2_bg     <= '0;
            s2_vs     <= 1'b0;
            s2_hs     <= 1'b0;
            s2_de     <= 1'b0;
        end else begin
            s2_hit    <= pe_hit;
            s2_blend  <= pe_blend;
            s2_idx    <= pe_idx;
            s2_colour <= pe_colour;
            s2_bg     <= s1_bg;
            s2_vs     <= s1_vs;
            s2_hs     <= s1_hs;
            s2_de     <= s1_de;
        end
    end

    // Half-and-half mix; two 7-bit halves never exceed 254, so no saturation.
    function automatic logic [7:0] avg_half(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a[7:1]} + {1'b0, b[7:1]};
    endfunction

    logic [23:0] mix_colour;

    // Choose blended or straight colour for the output stage.
    always_comb begin
        mix_colour = s2_colour;
        if (s2_hit && s2_blend) begin
            mix_colour = {avg_half(s2_colour[23:16], s2_bg[23:16]),
                          avg_half(s2_colour[15:8],  s2_bg[15:8]),
                          avg_half(s2_colour[7:0],   s2_bg[7:0])};
        end
    end

    // S3: drive outputs, forcing black and no hit during blanking.
    always_ff @(posedge pix_clk) begin
        if (!rstn_out) begin
            r_out     <= 8'd0;
            g_out     <= 8'd0;
            b_out     <= 8'd0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            vs_out    <= 1'b0;
            hs_out    <= 1'b0;
            de_out    <= 1'b0;
        end else begin
            vs_out <= s2_vs;
            hs_out <= s2_hs;
            de_out <= s2_de;
            if (s2_de) begin
                r_out     <= mix_colour[23:16];
                g_out     <= mix_colour[15:8];
                b_out     <= mix_colour[7:0];
                hit_valid <= s2_hit;
                hit_idx   <= s2_hit ? s2_idx : '0;
            end else begin
                r_out     <= 8'd0;
                g_out     <= 8'd0;
                b_out     <= 8'd0;
                hit_valid <= 1'b0;
                hit_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_layer_mixer.sv
module tb_hdmi_layer_mixer;

    logic         pix_clk = 1'b0;
    logic         rstn_out;
    logic         vs_in, hs_in, de_in;
    logic [23:0]  bg_data;
    logic [7:0]   layer_en, layer_mask, blend_half, blink_mask;
    logic [191:0] layer_data;
    logic         vs_out, hs_out, de_out, hit_valid;
    logic [7:0]   r_out, g_out, b_out, frame_cnt;
    logic [2:0]   hit_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 pix_clk = ~pix_clk;

    hdmi_layer_mixer dut (
        .pix_clk    (pix_clk),
        .rstn_out   (rstn_out),
        .vs_in      (vs_in),
        .hs_in      (hs_in),
        .de_in      (de_in),
        .bg_data    (bg_data),
        .layer_en   (layer_en),
        .layer_data (layer_data),
        .layer_mask (layer_mask),
        .blend_half (blend_half),
        .blink_mask (blink_mask),
        .vs_out     (vs_out),
        .hs_out     (hs_out),
        .de_out     (de_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .hit_valid  (hit_valid),
        .hit_idx    (hit_idx),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pix_clk);
            #1;
        end
    endtask

    task automatic set_layer(input int i, input logic [23:0] c);
        layer_data[24*i +: 24] = c;
    endtask

    task automatic vs_pulse();
        vs_in = 1'b1;
        de_in = 1'b0;
        step(1);
        vs_in = 1'b0;
        step(1);
    endtask

    task automatic chk_pix(input string tag, input logic [23:0] rgb, input logic hv, input logic [2:0] idx);
        chk({tag, "_rgb"}, {8'h0, r_out, g_out, b_out}, {8'h0, rgb});
        chk({tag, "_hit"}, {31'h0, hit_valid}, {31'h0, hv});
        chk({tag, "_idx"}, {29'h0, hit_idx}, {29'h0, idx});
    endtask

    initial begin
        // Reset with busy inputs: everything must stay cleared.
        rstn_out   = 1'b0;
        vs_in      = 1'b1;
        hs_in      = 1'b1;
        de_in      = 1'b1;
        bg_data    = 24'hABCDEF;
        layer_en   = 8'hFF;
        layer_data = '1;
        layer_mask = 8'hFF;
        blend_half = 8'h00;
        blink_mask = 8'h00;
        step(4);
        chk_pix("reset", 24'h000000, 1'b0, 3'd0);
        chk("reset_de", {31'h0, de_out}, 32'd0);
        chk("reset_vs", {31'h0, vs_out}, 32'd0);
        chk("reset_fc", {24'h0, frame_cnt}, 32'd0);

        // Release: background only, exactly 3 cycles of latency.
        vs_in      = 1'b0;
        layer_en   = 8'h00;
        bg_data    = 24'h102030;
        layer_data = '0;
        rstn_out   = 1'b1;
        step(2);
        chk("lat2_de", {31'h0, de_out}, 32'd0);
        chk("lat2_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
        step(1);
        chk_pix("bg", 24'h102030, 1'b0, 3'd0);
        chk("bg_de", {31'h0, de_out}, 32'd1);
        chk("bg_hs", {31'h0, hs_out}, 32'd1);

        // Priority: layers 2 and 3 hit, layer 2 wins.
        layer_en = 8'b0000_1100;
        set_layer(2, 24'hFF0000);
        set_layer(3, 24'h00FF00);
        step(3);
        chk_pix("prio", 24'hFF0000, 1'b1, 3'd2);

        // Mid-frame mask change is ignored until the next vs edge.
        layer_mask = 8'hFB;
        step(3);
        chk_pix("mask_mid", 24'hFF0000, 1'b1, 3'd2);
        vs_in = 1'b1;
        de_in = 1'b0;
        step(1);
        vs_in = 1'b0;
        de_in = 1'b1;
        chk("fc_one", {24'h0, frame_cnt}, 32'd1);
        step(2);
        chk("vs_dly", {31'h0, vs_out}, 32'd1);
        step(1);
        chk("vs_fall", {31'h0, vs_out}, 32'd0);
        chk_pix("mask_new", 24'h00FF00, 1'b1, 3'd3);

        // Blend layer 0 with background.
        layer_en   = 8'h01;
        blend_half = 8'h01;
        set_layer(0, 24'hFFFFFF);
        bg_data    = 24'h000000;
        step(3);
        chk_pix("blend0", 24'h7F7F7F, 1'b1, 3'd0);
        bg_data = 24'h020202;
        step(3);
        chk_pix("blend2", 24'h808080, 1'b1, 3'd0);

        // All layers hit: layer 0 wins, unblended.
        layer_en   = 8'hFF;
        blend_half = 8'h00;
        set_layer(0, 24'h123456);
        step(3);
        chk_pix("all_hit", 24'h123456, 1'b1, 3'd0);

        // Blanking forces black and no hit.
        de_in = 1'b0;
        step(3);
        chk_pix("blank", 24'h000000, 1'b0, 3'd0);
        chk("blank_de", {31'h0, de_out}, 32'd0);

        // Frame counter wraps after 256 edges in total.
        for (int k = 0; k < 254; k++) vs_pulse();
        chk("fc_255", {24'h0, frame_cnt}, 32'd255);
        vs_pulse();
        chk("fc_wrap", {24'h0, frame_cnt}, 32'd0);

        // Blinking layer 1: hidden for frames 0-31 when blink is built in.
        de_in      = 1'b1;
        layer_en   = 8'h02;
        blink_mask = 8'h02;
        layer_mask = 8'hFF;
        bg_data    = 24'h111111;
        set_layer(1, 24'hAABBCC);
        step(3);
`ifdef OVL_BLINK_EN
        chk_pix("blink_off", 24'h111111, 1'b0, 3'd0);
`else
        chk_pix("blink_off", 24'hAABBCC, 1'b1, 3'd1);
`endif
        for (int k = 0; k < 32; k++) vs_pulse();
        chk("fc_32", {24'h0, frame_cnt}, 32'd32);
        de_in = 1'b1;
        step(3);
        chk_pix("blink_on", 24'hAABBCC, 1'b1, 3'd1);

        // Reset mid-frame clears the counter and outputs at once.
        rstn_out = 1'b0;
        step(1);
        chk_pix("rst_mid", 24'h000000, 1'b0, 3'd0);
        chk("rst_mid_fc", {24'h0, frame_cnt}, 32'd0);
        chk("rst_mid_de", {31'h0, de_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
